// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - streaming 2x2 stride-2 signed max-pool with one half-row line buffer
`timescale 1ns/1ps
module max_pool_2x2 #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last
);

   localparam int LB_DEPTH = IMG_WIDTH / 2;
   localparam int COL_W    = (IMG_WIDTH > 1)  ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LB_AW    = (LB_DEPTH > 1)   ? $clog2(LB_DEPTH)   : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } state_t;

   state_t                       state_q;
   logic [COL_W-1:0]             col_q, col_d;
   logic [ROW_W-1:0]             row_q, row_d;
   logic signed [DATA_WIDTH-1:0] h_reg_q;
   logic signed [DATA_WIDTH-1:0] out_data_q;
   logic                         out_valid_q;
   logic                         out_last_q;
   logic signed [DATA_WIDTH-1:0] lbuf_q [LB_DEPTH];

   logic                         accept;
   logic                         col_wrap;
   logic                         pool_load;
   logic                         frame_end;
   logic [LB_AW-1:0]             lb_idx;
   logic signed [DATA_WIDTH-1:0] hmax;
   logic signed [DATA_WIDTH-1:0] lbuf_rd;
   logic signed [DATA_WIDTH-1:0] pool_max;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign col_wrap  = (col_q == COL_LAST);
   assign lb_idx    = LB_AW'(col_q >> 1);
   assign lbuf_rd   = lbuf_q[lb_idx];
   assign frame_end = (row_q == ROW_LAST) && col_wrap;

   // Operands are declared signed, so these compares are two's-complement.
   assign hmax      = (in_data > h_reg_q) ? in_data : h_reg_q;
   assign pool_max  = (hmax > lbuf_rd) ? hmax : lbuf_rd;
   assign pool_load = accept && (state_q == ODD_ROW) && col_q[0];

   always_comb begin
      col_d = col_q + 1'b1;
      row_d = row_q;
      if (col_wrap) begin
         col_d = '0;
         row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= EVEN_ROW;
         col_q       <= '0;
         row_q       <= '0;
         h_reg_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            if (!col_q[0]) begin
               h_reg_q <= in_data;
            end
            if (col_wrap) begin
               state_q <= (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end
         end
         // A new result may replace the beat completing on this same edge.
         if (pool_load) begin
            out_data_q  <= pool_max;
            out_valid_q <= 1'b1;
            out_last_q  <= frame_end;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end

   // Every entry is written on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (accept && (state_q == EVEN_ROW) && col_q[0]) begin
         lbuf_q[lb_idx] <= hmax;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - directed self-checking bench for max_pool_2x2
`timescale 1ns/1ps
module tb_max_pool_2x2;

   localparam int DW = 8;
   localparam int IW = 4;
   localparam int IH = 4;

   logic                 clk       = 1'b0;
   logic                 rst       = 1'b0;
   logic signed [DW-1:0] in_data   = '0;
   logic                 in_valid  = 1'b0;
   logic                 out_ready = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] out_data;
   logic                 out_valid;
   logic                 out_last;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int out_q[$];
   int last_q[$];
   int beat_q[$];
   int acc_q[$];

   max_pool_2x2 #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (IW),
      .IMG_HEIGHT (IH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   always #6.25 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake values seen at the falling edge are the ones the next rising edge uses.
   always @(negedge clk) begin
      if (rst) begin
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid && out_ready) begin
            out_q.push_back(int'(out_data));
            last_q.push_back(int'(out_last));
            beat_q.push_back(cyc);
         end
      end
   end

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed == expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
   endtask

   task automatic clear_q();
      out_q.delete();
      last_q.delete();
      beat_q.delete();
      acc_q.delete();
   endtask

   // mode 0: out_ready=1; 1: stall 5 clks at first out_valid; 2: toggling in_valid, random out_ready; 3: out_ready=0
   task automatic run_frame(input int px[$], input int mode);
      int  idx = 0;
      int  guard = 0;
      int  stall = 0;
      bit  stalled = 0;
      bit  acc;
      while (idx < px.size() && guard < 500) begin
         in_data  = DW'(px[idx]);
         in_valid = (mode == 2) ? (guard % 2 == 0) : 1'b1;
         case (mode)
            0: out_ready = 1'b1;
            1: begin
               if (!stalled && out_valid) begin
                  stall   = 5;
                  stalled = 1;
               end
               out_ready = (stall == 0);
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         @(negedge clk);
         acc = in_valid && in_ready;
         if (mode == 1 && stall > 0) begin
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_hold_data", int'(out_data), 5);
            stall--;
         end
         @(posedge clk);
         #1;
         if (acc) idx++;
         guard++;
      end
      in_valid = 1'b0;
      check("all_pixels_accepted", idx, px.size());
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_outputs(input string tag, input int exp[$], input int expl[$]);
      check($sformatf("%s_count", tag), out_q.size(), exp.size());
      foreach (exp[i]) begin
         if (i < out_q.size()) begin
            check($sformatf("%s_data%0d", tag, i), out_q[i], exp[i]);
            check($sformatf("%s_last%0d", tag, i), last_q[i], expl[i]);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int ramp[$];
      int neg[$];
      int two[$];
      int part[$];
      int exp[$];
      int expl[$];
      int pix[4];
      for (int i = 0; i < 16; i++) begin
         ramp.push_back(i);
         neg.push_back(-128 + i);
      end
      for (int i = 0; i < 16; i++) two.push_back(15 - i);
      two = {two, -1, -5, 3, -128, -9, -2, 0, -3, 100, -100, -50, -60, 99, 127, -70, -51};
      for (int i = 0; i < 6; i++) part.push_back(i);

      // reset state
      out_ready = 1'b1;
      do_reset();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_in_ready", int'(in_ready), 1);
      rst = 1'b1;
      clear_q();

      // continuous ramp, latency 1 clk from accepting edge
      run_frame(ramp, 0);
      drain();
      exp  = {5, 7, 13, 15};
      expl = {0, 0, 0, 1};
      check_outputs("ramp", exp, expl);
      check("ramp_accept_count", acc_q.size(), 16);
      pix = '{5, 7, 13, 15};
      if (acc_q.size() == 16 && beat_q.size() == 4) begin
         for (int j = 0; j < 4; j++)
            check($sformatf("ramp_latency%0d", j), beat_q[j] - acc_q[pix[j]], 1);
      end
      clear_q();

      // negative values exercise the signed compare
      run_frame(neg, 0);
      drain();
      exp  = {-123, -121, -115, -113};
      check_outputs("signed", exp, expl);
      clear_q();

      // downstream stall holds data and blocks input
      run_frame(ramp, 1);
      drain();
      exp  = {5, 7, 13, 15};
      check_outputs("stall", exp, expl);
      clear_q();

      // two back-to-back frames with bubbles and random backpressure
      run_frame(two, 2);
      drain();
      exp  = {15, 13, 7, 5, -1, 3, 127, -50};
      expl = {0, 0, 0, 1, 0, 0, 0, 1};
      check_outputs("b2b", exp, expl);
      clear_q();

      // reset mid-frame with a pending output
      run_frame(part, 3);
      check("pre_rst_pending", int'(out_valid), 1);
      do_reset();
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_last", int'(out_last), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      rst = 1'b1;
      clear_q();
      run_frame(ramp, 0);
      drain();
      exp  = {5, 7, 13, 15};
      expl = {0, 0, 0, 1};
      check_outputs("after_rst", exp, expl);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
